// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and defaults for the E-stage multiply/divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MFHI  = 3'd6,
        MD_MFLO  = 3'd7
    } mudeop_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - combinational 64-bit multiply/divide result with divide-by-zero flag
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;
    logic [63:0] prod;

    // Signed division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    always_comb begin
        a_neg    = !op[0] && rs[31];
        b_neg    = !op[0] && rt[31];
        a_mag    = a_neg ? -rs : rs;
        b_mag    = b_neg ? -rt : rt;
        b_safe   = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag    = a_mag / b_safe;
        r_mag    = a_mag % b_safe;
        div_zero = op[1] && (rt == 32'd0);
        if (op[0])
            prod = {32'd0, rs} * {32'd0, rt};
        else
            prod = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        if (op[1]) begin
            res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
            res_hi = a_neg ? -r_mag : r_mag;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

endmodule

// File: rtl/e_muldiv_unit.sv
// rtl/e_muldiv_unit.sv - multi-cycle mult/div responder with HI/LO registers and busy for hazard detection
module e_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        md,
    input  logic [2:0]  mudeop,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    md_state_e   state, state_nxt;
    logic [3:0]  cnt;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_dz;
    logic [31:0] core_hi, core_lo;
    logic        core_dz;
    logic        do_start, do_done, do_mthi, do_mtlo;

    muldiv_core u_core (
        .op       (mudeop),
        .rs       (rs_val),
        .rt       (rt_val),
        .res_hi   (core_hi),
        .res_lo   (core_lo),
        .div_zero (core_dz)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        do_done   = 1'b0;
        case (state)
            ST_IDLE: if (start && md && !mudeop[2]) begin
                do_start  = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: if (cnt == 4'd1) begin
                do_done   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Moves to HI/LO are only honoured when idle and not mixed with a start pulse.
    assign do_mthi  = (state == ST_IDLE) && md && !start && (mudeop == MD_MTHI);
    assign do_mtlo  = (state == ST_IDLE) && md && !start && (mudeop == MD_MTLO);
    assign md_stall = start | busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_dz <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            busy <= (state_nxt == ST_RUN);
            if (do_start) begin
                cnt     <= mudeop[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                pend_hi <= core_hi;
                pend_lo <= core_lo;
                pend_dz <= core_dz;
            end else if (state == ST_RUN) begin
                cnt <= cnt - 4'd1;
            end
            if (do_done && !pend_dz) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            if (do_mthi) hi <= rs_val;
            if (do_mtlo) lo <= rs_val;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (md && mudeop == MD_MFHI)      rdata = hi;
        else if (md && mudeop == MD_MFLO) rdata = lo;
    end

endmodule

// File: tb/tb_e_muldiv_unit.sv
// tb/tb_e_muldiv_unit.sv - directed vector bench for e_muldiv_unit
module tb_e_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        md = 1'b0;
    logic [2:0]  mudeop = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy, md_stall;
    logic [31:0] hi, lo, rdata;

    int n_checks = 0;
    int n_fail = 0;
    int viol_cnt = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    e_muldiv_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md       (md),
        .mudeop   (mudeop),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    // Protocol monitor: the hazard unit must never let a start through while busy.
    always @(posedge clk) if (reset && start && busy) viol_cnt++;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        logic        dz;
        string       name;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string name);
        int n;
        int exp_cyc;
        exp_cyc = op[1] ? 10 : 5;
        @(negedge clk);
        start = 1'b1; md = 1'b1; mudeop = op; rs_val = a; rt_val = b;
        #1 check({name, " md_stall"}, 32'(md_stall), 32'd1);
        @(negedge clk);
        start = 1'b0; md = 1'b0; rs_val = $urandom; rt_val = $urandom;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, 32'(n), 32'(exp_cyc));
        check({name, " hi"}, hi, eh);
        check({name, " lo"}, lo, el);
        md = 1'b1; mudeop = MD_MFHI;
        #1 check({name, " mfhi"}, rdata, eh);
        mudeop = MD_MFLO;
        #1 check({name, " mflo"}, rdata, el);
        md = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg"};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0, "multu"};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg"};
        vecs[3]  = '{MD_DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003, 1'b0, "divu"};
        vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_ovf"};
        vecs[5]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_min"};
        vecs[6]  = '{MD_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 1'b0, "divu_big"};
        vecs[7]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_negdiv"};
        vecs[8]  = '{MD_DIV,   32'hFFFFFFF8, 32'd3,        32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0, "div_bothrem"};
        vecs[9]  = '{MD_DIVU,  32'd5,        32'd0,        32'h0,        32'h0,        1'b1, "divu_zero"};
        vecs[10] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max"};
        vecs[11] = '{MD_DIV,   32'd12345,    32'd0,        32'h0,        32'h0,        1'b1, "div_zero"};
        vecs[12] = '{MD_MULT,  32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 1'b0, "mult_m1"};

        #12;
        check("rst busy", 32'(busy), 32'd0);
        check("rst md_stall", 32'(md_stall), 32'd0);
        check("rst hi", hi, 32'd0);
        check("rst lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            if (!vecs[i].dz) begin
                mhi = vecs[i].eh;
                mlo = vecs[i].el;
            end
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, mhi, mlo, vecs[i].name);
        end

        // mthi / mtlo then read back
        @(negedge clk);
        md = 1'b1; mudeop = MD_MTHI; rs_val = 32'h1234;
        @(negedge clk);
        mudeop = MD_MTLO; rs_val = 32'h5678;
        check("mthi busy", 32'(busy), 32'd0);
        @(negedge clk);
        mudeop = MD_MFLO;
        #1 check("mtlo rdata", rdata, 32'h5678);
        mudeop = MD_MFHI;
        #1 check("mthi rdata", rdata, 32'h1234);
        md = 1'b0;
        #1 check("rdata idle", rdata, 32'd0);
        mhi = 32'h1234; mlo = 32'h5678;
        run_op(MD_DIV, 32'd99, 32'd0, mhi, mlo, "div_zero_after_mt");

        // illegal decodes in idle: no busy, no HI/LO change
        @(negedge clk);
        start = 1'b1; md = 1'b0; mudeop = MD_MULT; rs_val = 32'd3; rt_val = 32'd3;
        @(negedge clk);
        check("start_md0 busy", 32'(busy), 32'd0);
        md = 1'b1; mudeop = MD_MTHI; rs_val = 32'hBAD0BAD0;
        @(negedge clk);
        start = 1'b0; md = 1'b0;
        check("start_mthi busy", 32'(busy), 32'd0);
        check("start_mthi hi", hi, mhi);

        // asynchronous reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; md = 1'b1; mudeop = MD_DIVU; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0; md = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rst busy", 32'(busy), 32'd0);
        check("async_rst hi", hi, 32'd0);
        check("async_rst lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mhi = 32'd0; mlo = 32'd0;
        repeat (12) @(negedge clk);
        check("post_rst hi stays", hi, 32'd0);
        run_op(MD_MULT, 32'd6, 32'd7, 32'd0, 32'd42, "mult_after_rst");

        // start and mthi injected while busy must be ignored
        check("viol before", 32'(viol_cnt), 32'd0);
        @(negedge clk);
        start = 1'b1; md = 1'b1; mudeop = MD_MULTU; rs_val = 32'd1000; rt_val = 32'd1000;
        @(negedge clk);
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 2) begin
                start = 1'b1; md = 1'b1; mudeop = MD_DIVU; rs_val = 32'd100; rt_val = 32'd3;
            end else if (n == 3) begin
                start = 1'b0; md = 1'b1; mudeop = MD_MTHI; rs_val = 32'hDEADBEEF;
            end else begin
                start = 1'b0; md = 1'b0; rs_val = $urandom; rt_val = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0; md = 1'b0;
        check("busy_inject cycles", 32'(n), 32'd5);
        check("busy_inject hi", hi, 32'd0);
        check("busy_inject lo", lo, 32'd1000000);
        check("viol seen", 32'(viol_cnt), 32'd1);
        repeat (3) @(negedge clk);
        check("busy_inject idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
